dda_spi_host: RTL and testbench

SPI mode-0 initiator that drives the DDA chip's SPI responder from the host/FPGA side of the board. It turns single-request transactions into framed SPI transfers. A write sends one 16-bit parameter word (icx, icy, k or d). A read clocks out the 4-byte state snapshot (x_hi, x_lo, y_hi, y_lo). It sits between the host test-harness logic and the chip pins (uio[0] CS_n, uio[1] MOSI, uio[2] MISO, uio[3] SCLK).

---
 rtl/dda_spi_pkg.sv | 36 +++
 rtl/dda_spi_host_if.sv | 26 ++
 rtl/spi_sclk_gen.sv | 51 +++++
 rtl/dda_spi_host.sv | 166 ++++++++++++++++
 tb/tb_dda_spi_host.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dda_spi_pkg.sv
// Shared constants, FSM state type and frame helpers for the DDA SPI initiator.
// Frame layout: a command byte, then either a 16-bit parameter word or the 4-byte state readback.
package dda_spi_pkg;

  localparam int CMD_WRITE_BIT = 7;

  localparam logic [1:0] ADDR_ICX = 2'd0;
  localparam logic [1:0] ADDR_ICY = 2'd1;
  localparam logic [1:0] ADDR_K   = 2'd2;
  localparam logic [1:0] ADDR_D   = 2'd3;

  localparam int WR_FRAME_BITS = 24;
  localparam int RD_FRAME_BITS = 40;
  localparam int STATE_BYTES   = 4;
  localparam int SHIFT_W       = 40;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_CS_GAP   = 3'd4
  } spi_state_e;

  // Index of the final bit in a frame; the bit counter stops here.
  function automatic logic [5:0] last_bit_idx(input logic is_write);
    logic [5:0] idx;
    if (is_write) begin
      idx = 6'(WR_FRAME_BITS - 1);
    end else begin
      idx = 6'(RD_FRAME_BITS - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dda_spi_host_if.sv
// Request/response bundle between the host harness and the DDA SPI initiator.
interface dda_spi_host_if #(
  parameter int N      = 16,
  parameter int ADDR_W = 2
);
  import dda_spi_pkg::*;

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [ADDR_W-1:0]        req_addr;
  logic [N-1:0]             req_data;
  logic                     done;
  logic [STATE_BYTES*8-1:0] rsp_data;

  modport master (
    output req_valid, req_write, req_addr, req_data,
    input  req_ready, done, rsp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_data,
    output req_ready, done, rsp_data
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// Half-period timer: ticks every CLK_DIV cycles while enabled and toggles SCLK on ticks
// when toggling is allowed; rise/fall strobes coincide with the edge that changes SCLK.
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic toggle_en,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic sclk
);

  localparam int              CNT_W    = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             sclk_r;
  logic             tick_s;

  // Strobes decoded from the counter so the FSM reacts on the same edge SCLK moves.
  always_comb begin
    tick_s = en && (cnt_r == CNT_LAST);
    tick   = tick_s;
    rise   = tick_s && toggle_en && !sclk_r;
    fall   = tick_s && toggle_en && sclk_r;
  end

  // Counter and SCLK register; SCLK parks low whenever the timer is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= '0;
      sclk_r <= 1'b0;
    end else if (!en) begin
      cnt_r  <= '0;
      sclk_r <= 1'b0;
    end else if (tick_s) begin
      cnt_r <= '0;
      if (toggle_en) begin
        sclk_r <= !sclk_r;
      end
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign sclk = sclk_r;

endmodule

// File: rtl/dda_spi_host.sv
// Mode-0 SPI initiator for the DDA chip: 24-bit parameter writes, 40-bit state reads.
// The first low half of bit 0 is the CS setup interval, so SHIFT begins at the first rise.
module dda_spi_host
  import dda_spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int N       = 16,
  parameter int ADDR_W  = 2
) (
  input  logic           clk,
  input  logic           rst,
  dda_spi_host_if.slave  bus,
  output logic           spi_cs_n,
  output logic           spi_sclk,
  output logic           spi_mosi,
  input  logic           spi_miso
);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("dda_spi_host: CLK_DIV must be >= 1");
  end
  if (N != 16) begin : g_bad_n
    $error("dda_spi_host: N must be 16");
  end
  if ((ADDR_W < 1) || (ADDR_W > CMD_WRITE_BIT)) begin : g_bad_addr_w
    $error("dda_spi_host: ADDR_W out of range");
  end

  spi_state_e              state_r;
  logic [SHIFT_W-1:0]      sh_r;
  logic [5:0]              bit_cnt_r;
  logic [5:0]              last_r;
  logic                    is_write_r;
  logic                    gap_r;
  logic [STATE_BYTES*8-1:0] rx_r;
  logic [STATE_BYTES*8-1:0] rsp_r;
  logic                    cs_n_r;
  logic                    mosi_r;
  logic                    done_r;
  logic                    ready_r;

  logic [7:0]              cmd_s;
  logic [SHIFT_W-1:0]      frame_s;
  logic                    sclk_en_s;
  logic                    toggle_en_s;
  logic                    tick_s;
  logic                    rise_s;
  logic                    fall_s;

  // Frame image for the pending request; reads send an all-zero command and fill bytes.
  always_comb begin
    cmd_s                = 8'h00;
    cmd_s[CMD_WRITE_BIT] = bus.req_write;
    cmd_s[ADDR_W-1:0]    = bus.req_addr;
    if (bus.req_write) begin
      frame_s = {cmd_s, bus.req_data, 16'h0000};
    end else begin
      frame_s = 40'h00_0000_0000;
    end
    sclk_en_s   = (state_r != ST_IDLE);
    toggle_en_s = (state_r == ST_CS_SETUP) || (state_r == ST_SHIFT);
  end

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (sclk_en_s),
    .toggle_en (toggle_en_s),
    .tick      (tick_s),
    .rise      (rise_s),
    .fall      (fall_s),
    .sclk      (spi_sclk)
  );

  // Frame sequencer with registered CS/MOSI/handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      sh_r       <= '0;
      bit_cnt_r  <= 6'd0;
      last_r     <= 6'd0;
      is_write_r <= 1'b0;
      gap_r      <= 1'b0;
      rx_r       <= '0;
      rsp_r      <= '0;
      cs_n_r     <= 1'b1;
      mosi_r     <= 1'b0;
      done_r     <= 1'b0;
      ready_r    <= 1'b1;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid && ready_r) begin
            is_write_r <= bus.req_write;
            last_r     <= last_bit_idx(bus.req_write);
            sh_r       <= frame_s;
            mosi_r     <= frame_s[SHIFT_W-1];
            bit_cnt_r  <= 6'd0;
            rx_r       <= '0;
            cs_n_r     <= 1'b0;
            ready_r    <= 1'b0;
            state_r    <= ST_CS_SETUP;
          end
        end
        ST_CS_SETUP: begin
          if (rise_s) begin
            rx_r    <= {rx_r[STATE_BYTES*8-2:0], spi_miso};
            state_r <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Command-byte MISO bits fall off the top of rx_r, leaving only the state bytes.
          if (rise_s) begin
            rx_r <= {rx_r[STATE_BYTES*8-2:0], spi_miso};
          end else if (fall_s) begin
            if (bit_cnt_r == last_r) begin
              mosi_r  <= 1'b0;
              state_r <= ST_CS_HOLD;
            end else begin
              bit_cnt_r <= bit_cnt_r + 6'd1;
              sh_r      <= {sh_r[SHIFT_W-2:0], 1'b0};
              mosi_r    <= sh_r[SHIFT_W-2];
            end
          end
        end
        ST_CS_HOLD: begin
          if (tick_s) begin
            cs_n_r  <= 1'b1;
            done_r  <= 1'b1;
            gap_r   <= 1'b0;
            state_r <= ST_CS_GAP;
            if (!is_write_r) begin
              rsp_r <= rx_r;
            end
          end
        end
        ST_CS_GAP: begin
          if (tick_s) begin
            if (gap_r) begin
              ready_r <= 1'b1;
              state_r <= ST_IDLE;
            end else begin
              gap_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cs_n_r  <= 1'b1;
          mosi_r  <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign spi_cs_n      = cs_n_r;
  assign spi_mosi      = mosi_r;
  assign bus.req_ready = ready_r;
  assign bus.done      = done_r;
  assign bus.rsp_data  = rsp_r;

endmodule

// File: tb/tb_dda_spi_host.sv
// Bench for dda_spi_host: two instances (CLK_DIV=2 and 1), a bench-side SPI responder,
// table-driven and random frames checked against timing/frame formulas.
module tb_dda_spi_host;
  import dda_spi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_v, valid_v, write_v, miso_v;
  logic [1:0]  addr_v [2];
  logic [15:0] data_v [2];

  logic        cs_n0, sclk0, mosi0, cs_n1, sclk1, mosi1;

  dda_spi_host_if #(.N(16), .ADDR_W(2)) bus0 ();
  dda_spi_host_if #(.N(16), .ADDR_W(2)) bus1 ();

  assign bus0.req_valid = valid_v[0];
  assign bus0.req_write = write_v[0];
  assign bus0.req_addr  = addr_v[0];
  assign bus0.req_data  = data_v[0];
  assign bus1.req_valid = valid_v[1];
  assign bus1.req_write = write_v[1];
  assign bus1.req_addr  = addr_v[1];
  assign bus1.req_data  = data_v[1];

  dda_spi_host #(.CLK_DIV(2), .N(16), .ADDR_W(2)) dut0 (
    .clk(clk), .rst(rst_v[0]), .bus(bus0),
    .spi_cs_n(cs_n0), .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_miso(miso_v[0])
  );

  dda_spi_host #(.CLK_DIV(1), .N(16), .ADDR_W(2)) dut1 (
    .clk(clk), .rst(rst_v[1]), .bus(bus1),
    .spi_cs_n(cs_n1), .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(miso_v[1])
  );

  typedef struct packed {
    logic        cs_n;
    logic        sclk;
    logic        mosi;
    logic        ready;
    logic        done;
    logic [31:0] rsp;
  } obs_t;

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [15:0] data;
    logic [39:0] resp;
    logic [39:0] exp_mosi;
    logic [31:0] exp_rsp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rsp_model [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic obs_t observe(input int d);
    obs_t o;
    if (d == 0) begin
      o.cs_n = cs_n0; o.sclk = sclk0; o.mosi = mosi0;
      o.ready = bus0.req_ready; o.done = bus0.done; o.rsp = bus0.rsp_data;
    end else begin
      o.cs_n = cs_n1; o.sclk = sclk1; o.mosi = mosi1;
      o.ready = bus1.req_ready; o.done = bus1.done; o.rsp = bus1.rsp_data;
    end
    return o;
  endfunction

  // Reference frame as the responder should see it, right-aligned (24 bits for writes).
  function automatic logic [39:0] model_mosi(input logic wr, input logic [1:0] addr, input logic [15:0] data);
    int v;
    if (wr) v = (128 + int'(addr)) * 65536 + int'(data);
    else    v = 0;
    return 40'(v);
  endfunction

  task automatic set_req(input int d, input logic v, input logic w, input logic [1:0] a, input logic [15:0] dt);
    valid_v[d] = v;
    write_v[d] = w;
    addr_v[d]  = a;
    data_v[d]  = dt;
  endtask

  // Issue one request and follow it to completion; label 1 is the cycle after acceptance.
  task automatic run_frame(input string tag, input int d, input int h, input logic wr,
                           input logic [1:0] addr, input logic [15:0] data, input logic [39:0] resp,
                           input logic [39:0] exp_mosi, input logic [31:0] exp_rsp,
                           input int busy_lbl, input int abort_rises);
    int b, limit, nrise, nfall, cs_low_lbl, cs_high_lbl, done_cnt, done_lbl, ready_lbl;
    int rise_bad, fall_bad, tail_bad;
    logic prev_sclk, prev_cs;
    logic [39:0] cap;
    logic [31:0] rsp_done;
    obs_t o;
    b = wr ? WR_FRAME_BITS : RD_FRAME_BITS;
    limit = 2 * h * b + 3 * h + 20;
    nrise = 0; nfall = 0; cs_low_lbl = -1; cs_high_lbl = -1; done_cnt = 0; done_lbl = -1;
    ready_lbl = -1; rise_bad = 0; fall_bad = 0; tail_bad = 0;
    prev_sclk = 1'b0; prev_cs = 1'b1; cap = '0; rsp_done = '0;
    o = observe(d);
    check({tag, " ready_before_req"}, 64'(o.ready), 64'(1));
    set_req(d, 1'b1, wr, addr, data);
    @(posedge clk); #1;
    set_req(d, 1'b0, wr, addr, data);
    for (int lbl = 1; lbl <= limit; lbl++) begin
      o = observe(d);
      if (!o.cs_n && cs_low_lbl < 0) cs_low_lbl = lbl;
      if (o.cs_n && !prev_cs && cs_high_lbl < 0) cs_high_lbl = lbl;
      if (o.sclk && !prev_sclk) begin
        if (lbl != 1 + h + 2 * h * nrise) rise_bad++;
        cap = {cap[38:0], o.mosi};
        nrise++;
      end
      if (!o.sclk && prev_sclk) begin
        nfall++;
        if (lbl != 1 + 2 * h * nfall) fall_bad++;
      end
      if (nfall == b && !o.cs_n && o.mosi) tail_bad++;
      if (o.done) begin
        done_cnt++;
        done_lbl = lbl;
        rsp_done = o.rsp;
      end
      if (o.ready) begin
        ready_lbl = lbl;
        break;
      end
      prev_sclk = o.sclk;
      prev_cs   = o.cs_n;
      // Responder shifts its next bit out after each SCLK fall.
      if (!o.cs_n && nfall < b) miso_v[d] = resp[39 - nfall];
      else                      miso_v[d] = 1'b0;
      if (lbl == busy_lbl)          set_req(d, 1'b1, 1'b1, 2'd3, 16'h14DD);
      else if (lbl == busy_lbl + 1) set_req(d, 1'b0, 1'b0, 2'd0, 16'h0000);
      if (abort_rises > 0 && nrise == abort_rises) begin
        rst_v[d] = 1'b1;
        @(posedge clk); #1;
        o = observe(d);
        rst_v[d]  = 1'b0;
        miso_v[d] = 1'b0;
        check({tag, " abort cs_n"}, 64'(o.cs_n), 64'(1));
        check({tag, " abort sclk"}, 64'(o.sclk), 64'(0));
        check({tag, " abort mosi"}, 64'(o.mosi), 64'(0));
        check({tag, " abort ready"}, 64'(o.ready), 64'(1));
        check({tag, " abort done"}, 64'(done_cnt + int'(o.done)), 64'(0));
        check({tag, " abort rsp"}, 64'(o.rsp), 64'(0));
        return;
      end
      @(posedge clk); #1;
    end
    miso_v[d] = 1'b0;
    check({tag, " cs_fall"}, 64'(cs_low_lbl), 64'(1));
    check({tag, " rise_count"}, 64'(nrise), 64'(b));
    check({tag, " rise_times_bad"}, 64'(rise_bad), 64'(0));
    check({tag, " fall_times_bad"}, 64'(fall_bad), 64'(0));
    check({tag, " mosi_bits"}, 64'(cap), 64'(exp_mosi));
    check({tag, " mosi_tail_bad"}, 64'(tail_bad), 64'(0));
    check({tag, " cs_rise"}, 64'(cs_high_lbl), 64'(1 + 2 * h * b + h));
    check({tag, " done_count"}, 64'(done_cnt), 64'(1));
    check({tag, " done_time"}, 64'(done_lbl), 64'(1 + 2 * h * b + h));
    check({tag, " rsp_at_done"}, 64'(rsp_done), 64'(exp_rsp));
    check({tag, " ready_time"}, 64'(ready_lbl), 64'(1 + 2 * h * b + 3 * h));
  endtask

  // Idle window: the bus must stay quiet and rsp_data must hold.
  task automatic idle_watch(input string tag, input int d, input int cycles, input logic [31:0] exp_rsp);
    int lows;
    obs_t o;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      o = observe(d);
      if (!o.cs_n) lows++;
    end
    check({tag, " cs_low_cycles"}, 64'(lows), 64'(0));
    check({tag, " rsp_held"}, 64'(o.rsp), 64'(exp_rsp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [5];
    obs_t        o;
    logic        wr;
    logic [1:0]  addr;
    logic [15:0] data;
    logic [39:0] resp;
    logic [31:0] exp_rsp;

    rst_v = 2'b11; valid_v = 2'b00; write_v = 2'b00; miso_v = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr_v[i] = 2'd0; data_v[i] = 16'h0000; rsp_model[i] = 32'h0;
    end

    repeat (3) @(posedge clk);
    #1;
    o = observe(0);
    check("reset cs_n", 64'(o.cs_n), 64'(1));
    check("reset sclk", 64'(o.sclk), 64'(0));
    check("reset mosi", 64'(o.mosi), 64'(0));
    check("reset ready", 64'(o.ready), 64'(1));
    check("reset done", 64'(o.done), 64'(0));
    check("reset rsp", 64'(o.rsp), 64'(0));
    o = observe(1);
    check("reset1 cs_n", 64'(o.cs_n), 64'(1));
    check("reset1 ready", 64'(o.ready), 64'(1));
    rst_v = 2'b00;
    @(posedge clk); #1;

    vecs[0] = '{wr: 1'b1, addr: ADDR_ICX, data: 16'hC000, resp: 40'h00_0000_0000, exp_mosi: 40'h80C000, exp_rsp: 32'h0000_0000};
    vecs[1] = '{wr: 1'b0, addr: 2'd0,     data: 16'h0000, resp: 40'hFF_C000_14CD, exp_mosi: 40'h0,      exp_rsp: 32'hC000_14CD};
    vecs[2] = '{wr: 1'b1, addr: ADDR_K,   data: 16'h14DD, resp: 40'hAA_5555_AAAA, exp_mosi: 40'h8214DD, exp_rsp: 32'hC000_14CD};
    vecs[3] = '{wr: 1'b1, addr: ADDR_ICY, data: 16'h0001, resp: 40'hFF_FFFF_FFFF, exp_mosi: 40'h810001, exp_rsp: 32'hC000_14CD};
    vecs[4] = '{wr: 1'b0, addr: ADDR_D,   data: 16'hFFFF, resp: 40'h00_1234_5678, exp_mosi: 40'h0,      exp_rsp: 32'h1234_5678};
    for (int i = 0; i < 5; i++) begin
      run_frame($sformatf("vec%0d", i), 0, 2, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].resp,
                vecs[i].exp_mosi, vecs[i].exp_rsp, 0, 0);
      rsp_model[0] = vecs[i].exp_rsp;
    end

    for (int i = 0; i < 6; i++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = 2'($urandom_range(0, 3));
      data = 16'($urandom);
      resp = {8'($urandom), 32'($urandom)};
      exp_rsp = wr ? rsp_model[0] : resp[31:0];
      run_frame($sformatf("rnd%0d", i), 0, 2, wr, addr, data, resp, model_mosi(wr, addr, data), exp_rsp, 0, 0);
      rsp_model[0] = exp_rsp;
    end

    run_frame("busy", 0, 2, 1'b0, 2'd0, 16'h0000, 40'hA5_0FF0_5AC3, 40'h0, 32'h0FF0_5AC3, 30, 0);
    rsp_model[0] = 32'h0FF0_5AC3;
    idle_watch("busy", 0, 30, rsp_model[0]);

    run_frame("abort", 0, 2, 1'b0, 2'd0, 16'h0000, 40'hFF_1122_3344, 40'h0, 32'h0, 0, 10);
    rsp_model[0] = 32'h0;
    run_frame("after_abort", 0, 2, 1'b1, ADDR_K, 16'h14DD, 40'h0, 40'h8214DD, rsp_model[0], 0, 0);

    run_frame("div1_wr", 1, 1, 1'b1, ADDR_D, 16'h1234, 40'h0, 40'h831234, 32'h0, 0, 0);
    run_frame("div1_rd", 1, 1, 1'b0, 2'd0, 16'h0000, 40'h00_DEAD_BEEF, 40'h0, 32'hDEAD_BEEF, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
